// File: rtl/sub32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub32_pkg
// Description : Shared defaults, FSM state encoding and sizing helper for the
//               serial 32-bit subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package sub32_pkg;

    localparam int c_def_width = 32;
    localparam int c_def_slice = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_run  = 2'd1;
    localparam state_t c_st_done = 2'd2;

    // Bits needed to count n values (0..n-1); returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub4_slice.sv
`default_nettype none
// ============================================================================
// Module      : sub4_slice
// Description : Combinational SLICE-bit subtract step: {o_co,o_s} = a + ~b + cin.
// Revision    : 1.0 - initial release
// ============================================================================
module sub4_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_s,
    output logic             o_co
);

    logic [SLICE:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{SLICE{1'b0}}, i_cin};
    assign o_s   = w_sum[SLICE-1:0];
    assign o_co  = w_sum[SLICE];

endmodule
`default_nettype wire

// File: rtl/sub32_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub32_serial
// Description : Serial subtractor, diff = a - b - bin, one SLICE-bit slice per
//               clock (LSB first) with start/done handshake and flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sub32_serial
    import sub32_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int SLICE = c_def_slice
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ov,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NSLICE - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_a_sh;
    logic [WIDTH-1:0]       r_b_sh;
    logic [WIDTH-SLICE-1:0] r_res_sh;
    logic                   r_carry;
    logic                   r_a_msb;
    logic                   r_b_msb;
    logic                   r_busy;
    logic                   r_done;
    logic [WIDTH-1:0]       r_diff;
    logic                   r_bout;
    logic                   r_ov;
    logic                   r_zero;

    logic [SLICE-1:0]       w_s;
    logic                   w_co;
    logic [WIDTH-1:0]       w_res_next;

    sub4_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a   (r_a_sh[SLICE-1:0]),
        .i_b   (r_b_sh[SLICE-1:0]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_co  (w_co)
    );

    // On the last slice this is the complete difference, so commit uses it directly.
    assign w_res_next = {w_s, r_res_sh};

    always_ff @(posedge m_clock) begin
        if (!p_reset) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ov     <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_carry <= ~bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_run;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    r_a_sh   <= {{SLICE{1'b0}}, r_a_sh[WIDTH-1:SLICE]};
                    r_b_sh   <= {{SLICE{1'b0}}, r_b_sh[WIDTH-1:SLICE]};
                    r_res_sh <= w_res_next[WIDTH-1:SLICE];
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_cnt_last) begin
                        r_diff  <= w_res_next;
                        r_bout  <= ~w_co;
                        r_ov    <= (r_a_msb != r_b_msb) & (w_res_next[WIDTH-1] != r_a_msb);
                        r_zero  <= ~|w_res_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_st_done;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ov   = r_ov;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_sub32_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub32_serial
// Description : Directed self-checking bench for sub32_serial with a result
//               scoreboard fed at start and drained at done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub32_serial;

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ov;
        logic        zero;
    } res_t;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        ov;
    logic        zero;

    res_t q[$];
    res_t last_res;
    int   n_assert = 0;
    int   n_fail   = 0;

    sub32_serial dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .ov      (ov),
        .zero    (zero)
    );

    always #5 m_clock = ~m_clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
        res_t        r;
        logic [32:0] full;
        full   = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
        r.diff = full[31:0];
        r.bout = full[32];
        r.ov   = (ma[31] != mb[31]) && (r.diff[31] != ma[31]);
        r.zero = (r.diff == 32'd0);
        return r;
    endfunction

    task automatic tick;
        @(posedge m_clock);
        #1;
    endtask

    task automatic check_out(input string tag, input res_t e);
        chk({tag, "_diff"}, {32'd0, diff}, {32'd0, e.diff});
        chk({tag, "_bout"}, {63'd0, bout}, {63'd0, e.bout});
        chk({tag, "_ov"},   {63'd0, ov},   {63'd0, e.ov});
        chk({tag, "_zero"}, {63'd0, zero}, {63'd0, e.zero});
    endtask

    task automatic pop_check(input string tag);
        res_t e;
        chk({tag, "_sb_entry"}, {63'd0, (q.size() != 0)}, 64'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check_out(tag, e);
            last_res = e;
        end
    endtask

    // One operation; with disturb set, operands change and start pulses mid-run.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tbin, input bit disturb);
        bit seen;
        int busy_cnt;
        q.push_back(model(ta, tb_v, tbin));
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_busy_start"}, {63'd0, busy}, 64'd1);
        busy_cnt = busy ? 1 : 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (disturb && k == 4) begin
                a = ~ta; b = 32'd0; bin = 1'b1; start = 1'b1;
            end
            tick;
            if (disturb && k == 4) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                chk({tag, "_latency"}, 64'(k), 64'd8);
                chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
                chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
                pop_check(tag);
            end else begin
                if (busy) busy_cnt++;
                if (k == 4) check_out({tag, "_hold"}, last_res);
            end
        end
        chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        tick;
        chk({tag, "_done_width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int   ndone;
        res_t e;
        p_reset = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        last_res = '0;
        tick; tick;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        check_out("rst", last_res);
        p_reset = 1'b1;
        tick;

        run_op("op_5_3",      32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        run_op("op_0_1",      32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_op("op_a_3_b1",   32'h0000_000A, 32'h0000_0003, 1'b1, 1'b0);
        run_op("op_min_1",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_op("op_max_m1",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("op_equal",    32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);

        // start held high: accepted in IDLE and DONE only, one result every 9 cycles
        a = 32'h0000_0100; b = 32'h0000_0001; bin = 1'b1;
        e = model(a, b, bin);
        for (int i = 0; i < 3; i++) q.push_back(e);
        start = 1'b1;
        tick;
        ndone = 0;
        for (int k = 1; k <= 35; k++) begin
            tick;
            if (k == 18) start = 1'b0;
            if (done) begin
                chk("held_done_pos", 64'(k), 64'(8 + 9 * ndone));
                pop_check("held");
                ndone++;
            end
        end
        chk("held_done_count", 64'(ndone), 64'd3);

        run_op("op_ignore", 32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            tick;
            chk("ignore_no_extra_done", {63'd0, done}, 64'd0);
        end

        // reset in the middle of a run aborts it without a done pulse
        a = 32'h0000_0055; b = 32'h0000_0011; bin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        p_reset = 1'b0;
        tick;
        p_reset = 1'b1;
        last_res = '0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        check_out("midrst", last_res);
        for (int k = 0; k < 12; k++) begin
            tick;
            chk("midrst_no_done", {63'd0, done}, 64'd0);
        end
        run_op("op_after_rst", 32'h0000_0055, 32'h0000_0011, 1'b0, 1'b0);

        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sub32_serial.md
Name: sub32_serial

Overview:
Sequential 32-bit subtractor computing diff = a - b - bin, the inverse operation of the team's combinational ripple adder chain.
- Processes one 4-bit slice per clock, least-significant slice first, so eight slices cover the word.
- Trades latency for area. Intended for the datapath where a compact SUB/CMP unit is needed.
- Start/done handshake. Results are registered and held until the next operation completes.

Parameters:
WIDTH, 32, operand and result width; must be a multiple of SLICE
SLICE, 4, bits processed per cycle
NSLICE, WIDTH/SLICE (8), derived slice count; not overridable

Ports:
m_clock  in  1  clock; all state updates on rising edge
p_reset  in  1  reset, synchronous, active-low
start    in  1  request; sampled only when busy=0
a        in  WIDTH  minuend; sampled on accepted start
b        in  WIDTH  subtrahend; sampled on accepted start
bin      in  1  borrow-in; sampled on accepted start
busy     out 1  high while an operation is in progress
done     out 1  one-cycle pulse; results valid from this cycle
diff     out WIDTH  registered result a-b-bin mod 2^WIDTH
bout     out 1  borrow-out (1 when unsigned a < b+bin)
ov       out 1  signed overflow
zero     out 1  diff == 0

Behaviour:
- Clock and reset: one clock, m_clock. Reset p_reset is synchronous and active-low.
- Reset (p_reset=0 at an edge) forces:
  - state=IDLE, busy=0, done=0;
  - diff=0, bout=0, ov=0, zero=0;
  - slice counter=0 and internal shift registers=0.
- Reset mid-operation aborts the operation with no done pulse. The latched operands are discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - start=1 at edge E latches a, b and bin, sets carry=~bin and cnt=0, and moves to RUN.
- RUN:
  - busy=1.
  - At each edge, compute {c,s} = a_sh[SLICE-1:0] + ~b_sh[SLICE-1:0] + carry.
  - Shift s into the top of the result shift register, shift a_sh and b_sh right by SLICE, set carry=c, and increment cnt.
  - At the edge where cnt==NSLICE-1: commit diff from the final shift value, set bout=~c, and compute ov and zero. Then go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back operations.
  - Outputs change only at commit.
- Latency: start accepted at edge E, result committed at edge E+NSLICE (E+8), done high during the cycle following E+8. Throughput is one result per NSLICE+1 cycles.
- start while busy=1 is ignored; there is no queuing. Operand changes after acceptance have no effect.
- Flags (all registered at commit):
  - ov = (a[W-1]!=b[W-1]) & (diff[W-1]!=a[W-1]), using the latched a and b.
  - zero = ~|diff.
  - bout = ~carry_out of the last slice.
- diff, bout, ov and zero are stable from commit until the next commit or reset.
- No X propagation: outputs are never undriven, including while idle.

Decomposition:
- Package sub32_pkg holds:
  - the WIDTH and SLICE defaults;
  - the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the counter width function clog2(NSLICE).
- One sub-module, sub4_slice: combinational SLICE-bit add of a + ~b + cin, producing s[SLICE-1:0] and co. It is instantiated once in the top.
- Top holds the FSM, counter, operand shift registers and result/flag registers.

Test Plan:
- Reset then a=5, b=3, bin=0, start -> busy 1 for 8 cycles, done pulse at E+9 cycle; diff=0x00000002, bout=0, ov=0, zero=0.
- a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1, ov=0, zero=0; a=0x0000000A, b=3, bin=1 -> diff=0x00000006, bout=0.
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, ov=1, bout=0; a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ov=1, bout=1.
- a=b=0x12345678, bin=0 -> diff=0, zero=1, bout=0; then start held high continuously -> ops accepted only in IDLE/DONE, done every 9 cycles, no extra pulses.
- Start accepted, then at RUN cycle 4 change a/b and pulse start -> ignored; result is that of the latched operands.
- Assert p_reset=0 at RUN cycle 3 -> next cycle busy=0, done=0, diff=0, all flags 0; no done pulse follows. A new start then completes normally with correct result.
